// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the MAC operand sequencer and its
// integration with the 16x16 MAC ALU.
package mac_seq_ctrl_pkg;

  localparam int MAC_DW = 16;
  localparam int MAC_AW = 39;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream and result port of the MAC sequencer, grouped as one bundle.
// The master side feeds operand pairs and consumes the final accumulator value.
interface mac_seq_ctrl_if
  import mac_seq_ctrl_pkg::*;
#(
  parameter int DW = MAC_DW,
  parameter int AW = MAC_AW
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_x;
  logic [DW-1:0] in_b;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;

  modport master (
    output in_valid,
    output in_x,
    output in_b,
    output res_ready,
    input  in_ready,
    input  res_valid,
    input  res_data
  );

  modport slave (
    input  in_valid,
    input  in_x,
    input  in_b,
    input  res_ready,
    output in_ready,
    output res_valid,
    output res_data
  );

endinterface

// File: rtl/mac_seq_ctrl.sv
// Operand sequencer for the MAC ALU: clears the accumulator, streams a
// programmable number of (x, b) pairs into it, then holds the result.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int DW    = MAC_DW,
  parameter int AW    = MAC_AW,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  mac_seq_ctrl_if.slave    bus,
  output logic [DW-1:0]    alu_x,
  output logic [DW-1:0]    alu_b,
  output logic             alu_valid,
  output logic             alu_clr,
  input  logic [AW-1:0]    acc_in
);

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    alu_x_q, alu_x_d;
  logic [DW-1:0]    alu_b_q, alu_b_d;
  logic             alu_valid_q, alu_valid_d;
  logic             in_ready_w;
  logic             hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      alu_x_q     <= '0;
      alu_b_q     <= '0;
      alu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      alu_x_q     <= alu_x_d;
      alu_b_q     <= alu_b_d;
      alu_valid_q <= alu_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    alu_x_d     = alu_x_q;
    alu_b_d     = alu_b_q;
    alu_valid_d = 1'b0;
    in_ready_w  = (state_q == RUN);
    hs          = bus.in_valid && in_ready_w;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = (len_q == '0) ? DRAIN : RUN;
      end
      RUN: begin
        if (hs) begin
          alu_x_d     = bus.in_x;
          alu_b_d     = bus.in_b;
          alu_valid_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = DRAIN;
          end
        end
      end
      // The last pair is still on alu_valid here and lands in the ALU at this edge.
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Clear follows rst_n combinationally so the ALU empties on the same reset edge.
  assign alu_clr       = !rst_n || (state_q == CLEAR);
  assign busy          = (state_q != IDLE);
  assign bus.in_ready  = in_ready_w;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = (state_q == DONE) ? acc_in : '0;
  assign alu_x         = alu_x_q;
  assign alu_b         = alu_b_q;
  assign alu_valid     = alu_valid_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: an ALU stand-in closes the accumulator loop and a
// transaction-level model predicts every output on every cycle.
module tb_mac_seq_ctrl;
  import mac_seq_ctrl_pkg::*;

  localparam int DW    = MAC_DW;
  localparam int AW    = MAC_AW;
  localparam int LEN_W = 10;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len   = '0;
  logic             busy;
  logic [DW-1:0]    alu_x, alu_b;
  logic             alu_valid, alu_clr;
  logic [AW-1:0]    acc_in;
  logic [AW-1:0]    acc_q;

  mac_seq_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  mac_seq_ctrl #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .bus       (bus),
    .alu_x     (alu_x),
    .alu_b     (alu_b),
    .alu_valid (alu_valid),
    .alu_clr   (alu_clr),
    .acc_in    (acc_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    chk_cnt++;
    if (act === want) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
  endtask

  // Unsigned 16x16 product with bit 31 sign-extended, as the ALU does it.
  function automatic logic [AW-1:0] ext_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [31:0] p;
    p = a * b;
    return {{(AW-32){p[31]}}, p};
  endfunction

  always @(posedge clk) begin
    if (alu_clr) acc_q <= '0;
    else if (alu_valid) acc_q <= acc_q + ext_prod(alu_x, alu_b);
  end
  assign acc_in = acc_q;

  // Transaction model: edges since start, pairs taken, running sum.
  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  bit            m_av     = 1'b0;
  bit            m_hs;
  int            m_edges  = 0;
  int            m_pairs  = 0;
  int            m_len    = 0;
  int            m_fin    = -1;
  logic [DW-1:0] m_x      = '0;
  logic [DW-1:0] m_b      = '0;
  logic [AW-1:0] m_sum    = '0;

  function automatic bit m_in_ready();
    return m_active && !m_done && (m_edges >= 1) && (m_pairs < m_len);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_av     = 1'b0;
      m_x      = '0;
      m_b      = '0;
    end else begin
      m_hs = bus.in_valid && m_in_ready();
      m_av = m_hs;
      if (m_hs) begin
        m_x = bus.in_x;
        m_b = bus.in_b;
        m_pairs++;
        m_sum += ext_prod(bus.in_x, bus.in_b);
        if (m_pairs == m_len) m_fin = m_edges + 1;
      end
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_done   = 1'b0;
          m_len    = int'(len);
          m_edges  = 0;
          m_pairs  = 0;
          m_sum    = '0;
          m_fin    = (len == '0) ? 1 : -1;
        end
      end else begin
        m_edges++;
        if (m_done) begin
          if (bus.res_ready) begin
            m_active = 1'b0;
            m_done   = 1'b0;
          end
        end else if (m_fin >= 0 && m_edges == m_fin + 1) begin
          m_done = 1'b1;
        end
      end
    end
  end

  int clr_cnt = 0;
  int av_cnt  = 0;
  int rdy_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy",      64'(busy),          64'(m_active));
      checkOutput("in_ready",  64'(bus.in_ready),  64'(m_in_ready()));
      checkOutput("alu_clr",   64'(alu_clr),       64'(!rst_n || (m_active && m_edges == 0)));
      checkOutput("alu_valid", 64'(alu_valid),     64'(m_av));
      checkOutput("alu_x",     64'(alu_x),         64'(m_x));
      checkOutput("alu_b",     64'(alu_b),         64'(m_b));
      checkOutput("res_valid", 64'(bus.res_valid), 64'(m_done));
      checkOutput("res_data",  64'(bus.res_data),  m_done ? 64'(m_sum) : 64'd0);
    end
    if (rst_n) begin
      if (alu_clr) clr_cnt++;
      if (alu_valid) av_cnt++;
      if (bus.in_ready) rdy_cnt++;
    end
  end

  logic [DW-1:0] px[$];
  logic [DW-1:0] pb[$];
  int            start_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    clr_cnt = 0;
    av_cnt  = 0;
    rdy_cnt = 0;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  // Present queued pairs, one per set bit of vmask, one cycle per bit.
  task automatic applyStimulus(input logic [31:0] vmask, input int ncyc);
    int k = 0;
    for (int i = 0; i < ncyc; i++) begin
      bus.in_valid = vmask[i];
      if (vmask[i]) begin
        bus.in_x = px[k];
        bus.in_b = pb[k];
      end
      tick();
      if (vmask[i]) k++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic [AW-1:0] data);
    int n = 0;
    lat  = -1;
    data = '0;
    while (n < 40 && !bus.res_valid) begin
      tick();
      n++;
    end
    if (bus.res_valid) begin
      lat  = cyc - start_cyc;
      data = bus.res_data;
    end else begin
      checkOutput("result_timeout", 64'd0, 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            lat;
    logic [AW-1:0] data;

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b1;

    tick();
    chk_en = 1'b1;
    checkOutput("rst_busy",      64'(busy),          64'd0);
    checkOutput("rst_res_valid", 64'(bus.res_valid), 64'd0);
    checkOutput("rst_alu_valid", 64'(alu_valid),     64'd0);
    checkOutput("rst_alu_clr",   64'(alu_clr),       64'd1);
    checkOutput("rst_acc_in",    64'(acc_in),        64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] len=3 back-to-back");
    clear_counts();
    px = '{16'd1, 16'd2, 16'd3};
    pb = '{16'd4, 16'd5, 16'd6};
    do_start(3);
    tick();
    applyStimulus(32'b111, 3);
    wait_result(lat, data);
    checkOutput("t1_latency", 64'(lat),  64'd5);
    checkOutput("t1_data",    64'(data), 64'd32);
    tick();
    checkOutput("t1_idle",    64'(busy),    64'd0);
    checkOutput("t1_clr_cnt", 64'(clr_cnt), 64'd1);

    $display("[TB] len=2 sign extension");
    px = '{16'hFFFF, 16'h0001};
    pb = '{16'hFFFF, 16'h0001};
    do_start(2);
    tick();
    applyStimulus(32'b11, 2);
    wait_result(lat, data);
    checkOutput("t2_latency", 64'(lat),  64'd4);
    checkOutput("t2_data",    64'(data), 64'h7F_FFFE_0002);
    tick();

    $display("[TB] len=4 with bubbles");
    clear_counts();
    px = '{16'd10, 16'd10, 16'd10, 16'd10};
    pb = '{16'd10, 16'd10, 16'd10, 16'd10};
    do_start(4);
    tick();
    applyStimulus(32'b1011001, 7);
    wait_result(lat, data);
    checkOutput("t3_latency", 64'(lat),  64'd9);
    checkOutput("t3_data",    64'(data), 64'd400);
    tick();
    checkOutput("t3_av_cnt",  64'(av_cnt), 64'd4);

    $display("[TB] len=0");
    clear_counts();
    do_start(0);
    wait_result(lat, data);
    checkOutput("t4_latency", 64'(lat),  64'd2);
    checkOutput("t4_data",    64'(data), 64'd0);
    tick();
    checkOutput("t4_rdy_cnt", 64'(rdy_cnt), 64'd0);

    $display("[TB] DONE held by res_ready=0");
    bus.res_ready = 1'b0;
    px = '{16'd2};
    pb = '{16'd3};
    do_start(1);
    tick();
    applyStimulus(32'b1, 1);
    wait_result(lat, data);
    checkOutput("t5_latency", 64'(lat),  64'd3);
    checkOutput("t5_data",    64'(data), 64'd6);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5_hold_data", 64'(bus.res_data), 64'd6);
      checkOutput("t5_hold_busy", 64'(busy),         64'd1);
      start = (i == 2);
      len   = LEN_W'(5);
      tick();
    end
    start         = 1'b1;
    len           = LEN_W'(7);
    bus.res_ready = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("t5_release_busy", 64'(busy), 64'd0);
    tick();
    checkOutput("t5_start_ignored", 64'(busy), 64'd0);

    $display("[TB] reset in RUN");
    px = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    pb = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    do_start(5);
    tick();
    applyStimulus(32'b11, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("t6_busy",      64'(busy),          64'd0);
    checkOutput("t6_in_ready",  64'(bus.in_ready),  64'd0);
    checkOutput("t6_alu_valid", 64'(alu_valid),     64'd0);
    checkOutput("t6_alu_x",     64'(alu_x),         64'd0);
    checkOutput("t6_alu_b",     64'(alu_b),         64'd0);
    checkOutput("t6_res_valid", 64'(bus.res_valid), 64'd0);
    checkOutput("t6_acc_in",    64'(acc_in),        64'd0);
    tick();
    checkOutput("t6_acc_hold",  64'(acc_in),        64'd0);
    px = '{16'd7};
    pb = '{16'd3};
    do_start(1);
    tick();
    applyStimulus(32'b1, 1);
    wait_result(lat, data);
    checkOutput("t6_latency", 64'(lat),  64'd3);
    checkOutput("t6_data",    64'(data), 64'd21);
    tick();
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
